// File: rtl/display_queue_pkg.sv
// Shared types and defaults for the display queue: FSM state encoding,
// default FIFO depth and hold time, and the timer width helper.
package display_queue_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam int DATA_W              = 32;
    localparam int DEFAULT_DEPTH       = 4;
    localparam int DEFAULT_HOLD_CYCLES = 50_000_000;

    // One spare bit so HOLD_CYCLES-1 always fits, including HOLD_CYCLES=1.
    function automatic int timer_width(input int hold_cycles);
        return $clog2(hold_cycles) + 1;
    endfunction

endpackage

// File: rtl/display_queue_fifo.sv
// display_fifo: DEPTH-entry FIFO holding values waiting to be shown, with
// registered full/empty flags and a sticky flag for discarded writes.
module display_fifo
    import display_queue_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              write_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              dropped_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic [AW:0]       count_d;
    logic              full_q;
    logic              empty_q;
    logic              dropped_q;
    logic              accept;
    logic              take;

    // Acceptance looks only at the registered full flag, so a pop in the
    // same cycle never frees a slot for a write that arrived while full.
    assign accept = write_i && !full_q;
    assign take   = pop_i && !empty_q;

    always_comb begin
        count_d = count_q;
        case ({accept, take})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            dropped_q <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (take) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == FULL_COUNT);
            empty_q <= (count_d == '0);
            if (write_i && full_q) begin
                dropped_q <= 1'b1;
            end
        end
    end

    // Storage is left unreset; the pointers alone define what is valid.
    always_ff @(posedge clock) begin
        if (reset_n && accept) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Asynchronous head read keeps the one-cycle write-to-display latency.
    assign head_o    = mem_q[rd_ptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign dropped_o = dropped_q;

endmodule

// File: rtl/display_queue.sv
// display_queue: buffers CPU output values and shows each one on `number`
// for at least HOLD_CYCLES clocks, in arrival order.
module display_queue
    import display_queue_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              write,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] number,
    output logic              full,
    output logic              empty,
    output logic              showing,
    output logic              dropped
);

    localparam int TW = timer_width(HOLD_CYCLES);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(HOLD_CYCLES - 1);

    state_t            state_q;
    logic [TW-1:0]     timer_q;
    logic [DATA_W-1:0] number_q;
    logic              showing_q;
    logic              pop;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_dropped;

    display_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .write_i  (write),
        .data_i   (data),
        .pop_i    (pop),
        .head_o   (fifo_head),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .dropped_o(fifo_dropped)
    );

    // Pop whenever a value is waiting and the display is free to change.
    assign pop = !fifo_empty && ((state_q == ST_IDLE) || (timer_q == '0));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            number_q  <= '0;
            showing_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        number_q  <= fifo_head;
                        timer_q   <= TIMER_LOAD;
                        state_q   <= ST_HOLD;
                        showing_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (timer_q != '0) begin
                        timer_q <= timer_q - 1'b1;
                    end else if (pop) begin
                        number_q <= fifo_head;
                        timer_q  <= TIMER_LOAD;
                    end else begin
                        state_q   <= ST_IDLE;
                        showing_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign number  = number_q;
    assign full    = fifo_full;
    assign empty   = fifo_empty;
    assign showing = showing_q;
    assign dropped = fifo_dropped;

endmodule

// File: tb/tb_display_queue.sv
// Randomized scoreboard bench for display_queue: a time-based queue model
// predicts every cycle's outputs; a separate monitor compares them.
module tb_display_queue;

    localparam int DEPTH = 4;
    localparam int HOLD  = 4;

    logic        clock;
    logic        reset_n;
    logic        write;
    logic [31:0] data;
    logic [31:0] number;
    logic        full, empty, showing, dropped;

    logic        rst1_n;
    logic        wr1;
    logic [31:0] d1;
    logic [31:0] num1;
    logic        full1, empty1, show1, drop1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] number;
        logic        full;
        logic        empty;
        logic        showing;
        logic        dropped;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: values waiting, value on display, and the edge at
    // which it was put there; a new value may appear HOLD edges later.
    logic [31:0] mq[$];
    logic [31:0] m_disp = 0;
    bit          m_idle = 1;
    bit          m_drop = 0;
    int          m_edge = 0;
    int          m_last = 0;

    display_queue #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .write  (write),
        .data   (data),
        .number (number),
        .full   (full),
        .empty  (empty),
        .showing(showing),
        .dropped(dropped)
    );

    display_queue #(.DEPTH(DEPTH), .HOLD_CYCLES(1)) dut1 (
        .clock  (clock),
        .reset_n(rst1_n),
        .write  (wr1),
        .data   (d1),
        .number (num1),
        .full   (full1),
        .empty  (empty1),
        .showing(show1),
        .dropped(drop1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic model_step(bit rst_v, bit wr_v, logic [31:0] d_v);
        int   pre;
        bit   could;
        exp_t e;
        m_edge++;
        if (!rst_v) begin
            mq.delete();
            m_disp = 0;
            m_idle = 1;
            m_drop = 0;
        end else begin
            pre   = mq.size();
            could = m_idle || (m_edge - m_last >= HOLD);
            if (could && pre > 0) begin
                m_disp = mq.pop_front();
                m_last = m_edge;
                m_idle = 0;
            end else if (could) begin
                m_idle = 1;
            end
            if (wr_v) begin
                if (pre == DEPTH) m_drop = 1;
                else mq.push_back(d_v);
            end
        end
        e.number  = m_disp;
        e.full    = (mq.size() == DEPTH);
        e.empty   = (mq.size() == 0);
        e.showing = !m_idle;
        e.dropped = m_drop;
        exp_q.push_back(e);
    endtask

    task automatic drive(bit r, bit w, logic [31:0] d);
        @(negedge clock);
        reset_n = r;
        write   = w;
        data    = d;
        model_step(r, w, d);
    endtask

    // Monitor: one expected record per clock edge, compared after the edge.
    initial begin
        exp_t        e;
        logic [31:0] last_num;
        last_num = 0;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("number",  number,  e.number);
                chk("full",    full,    e.full);
                chk("empty",   empty,   e.empty);
                chk("showing", showing, e.showing);
                chk("dropped", dropped, e.dropped);
                if (number !== last_num) begin
                    $display("[TB] t=%0t number -> %0d", $time, number);
                    last_num = number;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wr_pct;
        int waited;
        reset_n = 0; write = 0; data = 0;
        rst1_n  = 0; wr1   = 0; d1   = 0;

        drive(0, 0, 0);
        drive(0, 0, 0);

        // Single value: shown, then display released with value retained.
        drive(1, 1, 123);
        repeat (7) drive(1, 0, 0);

        // Three back-to-back values.
        drive(1, 1, 1); drive(1, 1, 2); drive(1, 1, 3);
        repeat (12) drive(1, 0, 0);

        // Overflow: sixth write hits a full FIFO.
        for (int i = 1; i <= 6; i++) drive(1, 1, i);
        repeat (24) drive(1, 0, 0);

        // Reset in the middle of HOLD, with a write presented during reset.
        drive(1, 1, 5); drive(1, 1, 6); drive(1, 0, 0);
        drive(0, 1, 99);
        repeat (8) drive(1, 0, 0);

        // Slow stream across pointer wrap.
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 1000 + i);
            repeat (4) drive(1, 0, 0);
        end
        repeat (6) drive(1, 0, 0);

        // Random traffic with varying write density and occasional reset.
        wr_pct = 30;
        for (int c = 0; c < 600; c++) begin
            if (c % 50 == 0) wr_pct = $urandom_range(5, 95);
            drive(($urandom_range(0, 199) != 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < wr_pct) ? 1'b1 : 1'b0,
                  $urandom);
        end
        repeat (30) drive(1, 0, 0);

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clock);
            waited++;
        end
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);

        // HOLD_CYCLES=1 instance: values change on consecutive edges.
        @(negedge clock); rst1_n = 0; wr1 = 0;
        @(negedge clock); rst1_n = 1; wr1 = 1; d1 = 7;
        @(posedge clock); #1;
        chk("h1_empty_t", empty1, 0);
        @(negedge clock); d1 = 8;
        @(posedge clock); #1;
        chk("h1_number_t1", num1, 7);
        chk("h1_showing_t1", show1, 1);
        @(negedge clock); wr1 = 0;
        @(posedge clock); #1;
        chk("h1_number_t2", num1, 8);
        chk("h1_showing_t2", show1, 1);
        @(posedge clock); #1;
        chk("h1_number_t3", num1, 8);
        chk("h1_showing_t3", show1, 0);
        chk("h1_empty_t3", empty1, 1);
        chk("h1_dropped", drop1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
